alu_share_arbiter: RTL and testbench

//  Shares the single 16-bit ALU between two requesters, e.g. the EX stage and an address/branch unit.

---
 rtl/alu_share_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one 16-bit ALU between two requesters.
// The winner's operation drives the ALU in the same cycle. The ALU result is
// captured in a single-entry response buffer, and the N/Z/V flag register is
// updated bit by bit under the ALU's enable mask.
module alu_share_arbiter #(
   parameter int DATA_W = 16,
   parameter int OP_W   = 4,
   parameter int FLAG_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [FLAG_W-1:0] alu_flags,
   input  logic [FLAG_W-1:0] alu_en,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_data,
   output logic [FLAG_W-1:0] rsp_flags,
   output logic [FLAG_W-1:0] flag_reg
);

   typedef enum logic {IDLE, RESP} state_t;

   state_t            state_q, state_d;
   logic              prio_q, prio_d;
   logic              rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;
   logic [FLAG_W-1:0] flag_reg_q, flag_reg_d;

   logic can_accept;
   logic grant0;
   logic grant1;
   logic accept;
   logic winner;

   // Pick the winner. A lone requester always wins. When both request, prio_q
   // breaks the tie. The buffer takes new work only when it is empty or is
   // being drained this cycle.
   always_comb begin
      can_accept = (state_q == IDLE) | rsp_ready;
      grant1     = req1_valid & (~req0_valid | prio_q);
      grant0     = req0_valid & (~req1_valid | ~prio_q);
      winner     = grant1;
      accept     = can_accept & (grant0 | grant1);
      req0_ready = can_accept & grant0;
      req1_ready = can_accept & grant1;
   end

   // Drive the winner's operation to the ALU. Drive zeros when nobody requests.
   always_comb begin
      alu_op  = '0;
      alu_in1 = '0;
      alu_in2 = '0;
      if (grant1) begin
         alu_op  = req1_op;
         alu_in1 = req1_a;
         alu_in2 = req1_b;
      end else if (grant0) begin
         alu_op  = req0_op;
         alu_in1 = req0_a;
         alu_in2 = req0_b;
      end
   end

   // Compute next state. An accept loads the buffer, flips priority and commits
   // the masked flags. A drain with no new accept empties the buffer.
   // Otherwise everything holds.
   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_flags_d = rsp_flags_q;
      flag_reg_d  = flag_reg_q;
      if (accept) begin
         state_d     = RESP;
         prio_d      = ~winner;
         rsp_id_d    = winner;
         rsp_data_d  = alu_out;
         rsp_flags_d = alu_flags;
         for (int i = 0; i < FLAG_W; i++) begin
            flag_reg_d[i] = alu_en[i] ? alu_flags[i] : flag_reg_q[i];
         end
      end else if (state_q == RESP && rsp_ready) begin
         state_d = IDLE;
      end
   end

   // Register the FSM and buffer state. Reset drops any buffered response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         prio_q      <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
         rsp_flags_q <= '0;
         flag_reg_q  <= '0;
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_flags_q <= rsp_flags_d;
         flag_reg_q  <= flag_reg_d;
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_flags = rsp_flags_q;
   assign flag_reg  = flag_reg_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter, with a small behavioural ALU
// attached to the arbiter's ALU port.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [3:0]  req0_op, req1_op;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  alu_op;
   logic [15:0] alu_in1, alu_in2, alu_out;
   logic [2:0]  alu_flags, alu_en;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [15:0] rsp_data;
   logic [2:0]  rsp_flags, flag_reg;

   int total = 0;
   int bad   = 0;

   alu_share_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_out(alu_out), .alu_flags(alu_flags), .alu_en(alu_en),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_flags(rsp_flags), .flag_reg(flag_reg)
   );

   always #5 clk = ~clk;

   // Behavioural ALU model.
   // Op 0: ADD, all flags written.
   // Op 2: XOR, only Z written.
   // Op 8: add with no flag writes.
   // Flags are ordered {N, Z, V}.
   always_comb begin
      logic v;
      v       = 1'b0;
      alu_out = '0;
      alu_en  = 3'b000;
      case (alu_op)
         4'd0: begin
            alu_out = alu_in1 + alu_in2;
            v       = (alu_in1[15] == alu_in2[15]) && (alu_out[15] != alu_in1[15]);
            alu_en  = 3'b111;
         end
         4'd2: begin
            alu_out = alu_in1 ^ alu_in2;
            alu_en  = 3'b010;
         end
         4'd8: begin
            alu_out = alu_in1 + alu_in2;
            alu_en  = 3'b000;
         end
         default: ;
      endcase
      alu_flags = {alu_out[15], alu_out == 16'h0, v};
   end

   task automatic applyStimulus(input logic v0, input logic [3:0] op0,
                                input logic [15:0] a0, input logic [15:0] b0,
                                input logic v1, input logic [3:0] op1,
                                input logic [15:0] a1, input logic [15:0] b1,
                                input logic rr);
      req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
      rsp_ready  = rr;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      checkOutput("rst_valid", rsp_valid, 0);
      checkOutput("rst_id", rsp_id, 0);
      checkOutput("rst_data", rsp_data, 0);
      checkOutput("rst_flags", rsp_flags, 0);
      checkOutput("rst_flagreg", flag_reg, 0);
      rst = 1'b0;
      #1;
      checkOutput("idle_alu_op", alu_op, 0);
      checkOutput("idle_alu_in1", alu_in1, 0);
      checkOutput("idle_alu_in2", alu_in2, 0);

      // T1: ADD 0x7FFF + 1 overflows into the sign bit.
      applyStimulus(1, 4'd0, 16'h7FFF, 16'h0001, 0, 0, 0, 0, 1);
      #1;
      checkOutput("t1_ready0", req0_ready, 1);
      checkOutput("t1_ready1", req1_ready, 0);
      checkOutput("t1_alu_in1", alu_in1, 16'h7FFF);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("t1_valid", rsp_valid, 1);
      checkOutput("t1_id", rsp_id, 0);
      checkOutput("t1_data", rsp_data, 16'h8000);
      checkOutput("t1_flags", rsp_flags, 3'b101);
      checkOutput("t1_flagreg", flag_reg, 3'b101);

      // T2: XOR equal operands. Only the Z flag is written.
      applyStimulus(0, 0, 0, 0, 1, 4'd2, 16'h1234, 16'h1234, 1);
      #1;
      checkOutput("t2_ready1", req1_ready, 1);
      checkOutput("t2_alu_op", alu_op, 4'd2);
      tick();
      checkOutput("t2_data", rsp_data, 16'h0000);
      checkOutput("t2_id", rsp_id, 1);
      checkOutput("t2_flags", rsp_flags, 3'b010);
      checkOutput("t2_flagreg", flag_reg, 3'b111);

      // T3: both requesters valid every cycle, with grants alternating 0,1,0,1.
      applyStimulus(1, 4'd0, 16'd1, 16'd1, 1, 4'd0, 16'd2, 16'd2, 1);
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput("t3_ready0", req0_ready, (i % 2 == 0));
         checkOutput("t3_ready1", req1_ready, (i % 2 == 1));
         tick();
         checkOutput("t3_valid", rsp_valid, 1);
         checkOutput("t3_id", rsp_id, i % 2);
         checkOutput("t3_data", rsp_data, (i % 2 == 0) ? 16'd2 : 16'd4);
      end
      checkOutput("t3_flagreg", flag_reg, 3'b000);

      // T4: stall the consumer for three cycles. The buffered response must hold.
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("t4_ready0", req0_ready, 0);
         checkOutput("t4_ready1", req1_ready, 0);
         tick();
         checkOutput("t4_valid", rsp_valid, 1);
         checkOutput("t4_id", rsp_id, 1);
         checkOutput("t4_data", rsp_data, 16'd4);
         checkOutput("t4_flagreg", flag_reg, 3'b000);
      end
      rsp_ready = 1'b1;
      #1;
      checkOutput("t4_rel_ready0", req0_ready, 1);
      tick();
      checkOutput("t4_rel_id", rsp_id, 0);
      checkOutput("t4_rel_data", rsp_data, 16'd2);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      checkOutput("t4_drain_valid", rsp_valid, 0);

      // T5: set flags to 101, then run an op whose enable mask writes nothing.
      applyStimulus(1, 4'd0, 16'h7FFF, 16'h0001, 0, 0, 0, 0, 1);
      tick();
      checkOutput("t5_pre_flagreg", flag_reg, 3'b101);
      applyStimulus(1, 4'd8, 16'd3, 16'd4, 0, 0, 0, 0, 1);
      tick();
      checkOutput("t5_data", rsp_data, 16'd7);
      checkOutput("t5_flags", rsp_flags, 3'b000);
      checkOutput("t5_flagreg", flag_reg, 3'b101);
      checkOutput("t5_valid", rsp_valid, 1);

      // T6: reset while a response is buffered. After reset, requester 0 wins first.
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      tick();
      checkOutput("t6_valid", rsp_valid, 0);
      checkOutput("t6_flagreg", flag_reg, 3'b000);
      rst = 1'b0;
      applyStimulus(1, 4'd0, 16'd5, 16'd6, 1, 4'd0, 16'd7, 16'd8, 1);
      #1;
      checkOutput("t6_ready0", req0_ready, 1);
      checkOutput("t6_ready1", req1_ready, 0);
      tick();
      checkOutput("t6_id", rsp_id, 0);
      checkOutput("t6_data", rsp_data, 16'd11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
